// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/data memory req/ack handshake bundle between the controller and memories.
// Latency: none (wires only).
// Backpressure: requester holds req until the memory returns ack; ack without req is ignored.
interface multicycle_ctrl_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] instr;
    logic               imem_req;
    logic               imem_ack;
    logic               dmem_req;
    logic               dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        input  instr,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output instr,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core; MULTICYCLE_CTRL_PERF_EN adds cyc_cnt/ret_cnt.
// Latency: branch 3, ALU/jump/store 4, load 5 cycles with zero-wait acks; each ack wait cycle adds one.
// Backpressure: imem/dmem req held until ack; run=0 only blocks raising a new fetch request.
module multicycle_ctrl #(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 4
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    multicycle_ctrl_if.master    mif,
    input  logic                 zero,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           PCsrc,
    output logic [2:0]           ALUOp,
    output logic                 alucsrc,
    output logic                 m2reg,
    output logic                 wmem,
    output logic                 memc,
    output logic                 wreg,
    output logic                 jal,
    output logic                 illegal,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [CNT_W-1:0]     cyc_cnt,
    output logic [CNT_W-1:0]     ret_cnt,
`endif
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;
    logic            req_hold_q;
    logic            req_c;
    logic            ir_we_c;
    logic            dmem_req_c;
    logic [3:0]      op4;
    logic            op_hi;
    logic [2:0]      alu_dec;
    logic            csrc_dec;
    logic            unused_instr;

    assign op4 = op_q[3:0];

    // Opcode bits above the 16-entry map make the instruction illegal.
    generate
        if (OP_W > 4) begin : g_wide_op
            assign op_hi = |op_q[OP_W-1:4];
        end else begin : g_narrow_op
            assign op_hi = 1'b0;
        end
    endgenerate

    // Operand fields of the instruction are consumed by the datapath, not here.
    assign unused_instr = ^mif.instr[INSTR_W-OP_W-1:0];

    // Reset must force every output low even while run is high, so the
    // FETCH-state request and load strobe are qualified with rst_n.
    assign mif.imem_req = req_c & rst_n;
    assign ir_we        = ir_we_c & rst_n;
    assign mif.dmem_req = dmem_req_c;
    assign state        = state_q;

    // Latched-opcode decode to ALU operation and operand source.
    always_comb begin
        alu_dec  = 3'd0;
        csrc_dec = 1'b0;
        case (op4)
            4'd1:                     csrc_dec = 1'b1;
            4'd2:                     alu_dec  = 3'd4;
            4'd3:                     alu_dec  = 3'd5;
            4'd4, 4'd5, 4'd6, 4'd7:   csrc_dec = 1'b1;
            4'd9:                     alu_dec  = 3'd1;
            4'd10:                    alu_dec  = 3'd2;
            4'd11:                    alu_dec  = 3'd3;
            4'd12:                    csrc_dec = 1'b1;
            4'd13: begin alu_dec = 3'd1; csrc_dec = 1'b1; end
            4'd14: begin alu_dec = 3'd2; csrc_dec = 1'b1; end
            4'd15: begin alu_dec = 3'd3; csrc_dec = 1'b1; end
            default: ;
        endcase
        if (op_hi) begin
            alu_dec  = 3'd0;
            csrc_dec = 1'b0;
        end
    end

    // State register, opcode latch and sticky fetch request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            op_q       <= '0;
            req_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_hold_q <= req_c & ~mif.imem_ack;
            if (ir_we_c) begin
                op_q <= mif.instr[INSTR_W-1 -: OP_W];
            end
        end
    end

    // Next-state and per-state datapath strobes.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        pc_we      = 1'b0;
        PCsrc      = 2'd0;
        ALUOp      = 3'd0;
        alucsrc    = 1'b0;
        m2reg      = 1'b0;
        wmem       = 1'b0;
        memc       = 1'b0;
        wreg       = 1'b0;
        jal        = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                // Once raised the request stays up until ack, independent of run.
                req_c = run | req_hold_q;
                if (req_c && mif.imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                ALUOp   = alu_dec;
                alucsrc = csrc_dec;
                if (op_hi) begin
                    pc_we   = 1'b1;
                    illegal = 1'b1;
                    state_d = FETCH;
                end else if (op4 == 4'd2 || op4 == 4'd3) begin
                    // zero==0 means the branch condition holds.
                    pc_we   = 1'b1;
                    PCsrc   = zero ? 2'd0 : 2'd1;
                    state_d = FETCH;
                end else if (op4[3:2] == 2'b01) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                // lb=4, lw=5, sb=6, sw=7: bit1 selects store, bit0 selects 2-byte.
                ALUOp      = alu_dec;
                alucsrc    = csrc_dec;
                dmem_req_c = 1'b1;
                wmem       = op4[1];
                memc       = op4[0];
                if (mif.dmem_ack) begin
                    if (op4[1]) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                ALUOp   = alu_dec;
                alucsrc = csrc_dec;
                wreg    = 1'b1;
                pc_we   = 1'b1;
                m2reg   = (op4[3:2] == 2'b01);
                jal     = (op4[3:1] == 3'b000);
                if (op4 == 4'd0) begin
                    PCsrc = 2'd1;
                end else if (op4 == 4'd1) begin
                    PCsrc = 2'd2;
                end
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Busy-cycle and retired-instruction counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state_q != FETCH || req_c) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (pc_we) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction stream with a retirement scoreboard.
// Latency: n/a.
// Backpressure: bench memory model inserts per-instruction fetch/data wait cycles.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    typedef struct {
        logic [15:0] instr;
        int          iwait;
        int          dwait;
        logic        zero;
    } prog_t;

    typedef struct {
        string tag;
        int    pcs, alu, cs, m2r, jl, il, wc, lat, dc, wm, mc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, run, sel;
    logic        zero_v, ack_i, ack_d;
    logic [15:0] instr_v;

    prog_t prog_q[$];
    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.INSTR_W(16)) ifa ();
    multicycle_ctrl_if #(.INSTR_W(16)) ifb ();

    assign ifa.instr    = instr_v;
    assign ifa.imem_ack = ack_i & ~sel;
    assign ifa.dmem_ack = ack_d & ~sel;
    assign ifb.instr    = instr_v;
    assign ifb.imem_ack = ack_i & sel;
    assign ifb.dmem_ack = ack_d & sel;

    logic       a_ir_we, a_pc_we, a_alucsrc, a_m2reg, a_wmem, a_memc, a_wreg, a_jal, a_illegal;
    logic [1:0] a_PCsrc;
    logic [2:0] a_ALUOp, a_state;
    logic       b_ir_we, b_pc_we, b_alucsrc, b_m2reg, b_wmem, b_memc, b_wreg, b_jal, b_illegal;
    logic [1:0] b_PCsrc;
    logic [2:0] b_ALUOp, b_state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] a_cyc, a_ret, b_cyc, b_ret;
`endif

    multicycle_ctrl #(.INSTR_W(16), .OP_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run & ~sel), .mif(ifa), .zero(zero_v),
        .ir_we(a_ir_we), .pc_we(a_pc_we), .PCsrc(a_PCsrc), .ALUOp(a_ALUOp),
        .alucsrc(a_alucsrc), .m2reg(a_m2reg), .wmem(a_wmem), .memc(a_memc),
        .wreg(a_wreg), .jal(a_jal), .illegal(a_illegal),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .cyc_cnt(a_cyc), .ret_cnt(a_ret),
`endif
        .state(a_state)
    );

    multicycle_ctrl #(.INSTR_W(16), .OP_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run & sel), .mif(ifb), .zero(zero_v),
        .ir_we(b_ir_we), .pc_we(b_pc_we), .PCsrc(b_PCsrc), .ALUOp(b_ALUOp),
        .alucsrc(b_alucsrc), .m2reg(b_m2reg), .wmem(b_wmem), .memc(b_memc),
        .wreg(b_wreg), .jal(b_jal), .illegal(b_illegal),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .cyc_cnt(b_cyc), .ret_cnt(b_ret),
`endif
        .state(b_state)
    );

    // Observed DUT: A normally, B while sel=1.
    logic       m_imem_req, m_dmem_req, m_ir_we, m_pc_we, m_alucsrc, m_m2reg;
    logic       m_wmem, m_memc, m_wreg, m_jal, m_illegal;
    logic [1:0] m_PCsrc;
    logic [2:0] m_ALUOp, m_state;
    assign m_imem_req = sel ? ifb.imem_req : ifa.imem_req;
    assign m_dmem_req = sel ? ifb.dmem_req : ifa.dmem_req;
    assign m_ir_we    = sel ? b_ir_we   : a_ir_we;
    assign m_pc_we    = sel ? b_pc_we   : a_pc_we;
    assign m_PCsrc    = sel ? b_PCsrc   : a_PCsrc;
    assign m_ALUOp    = sel ? b_ALUOp   : a_ALUOp;
    assign m_alucsrc  = sel ? b_alucsrc : a_alucsrc;
    assign m_m2reg    = sel ? b_m2reg   : a_m2reg;
    assign m_wmem     = sel ? b_wmem    : a_wmem;
    assign m_memc     = sel ? b_memc    : a_memc;
    assign m_wreg     = sel ? b_wreg    : a_wreg;
    assign m_jal      = sel ? b_jal     : a_jal;
    assign m_illegal  = sel ? b_illegal : a_illegal;
    assign m_state    = sel ? b_state   : a_state;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".outs"}, int'({m_imem_req, m_dmem_req, m_ir_we, m_pc_we, m_PCsrc, m_ALUOp,
                                  m_alucsrc, m_m2reg, m_wmem, m_memc, m_wreg, m_jal, m_illegal}), 0);
        chk({tag, ".state"}, int'(m_state), 0);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Queue one instruction for the memory model and its expected retirement.
    task automatic issue(input string tag, input logic [15:0] ins, input int iw, input int dw,
                         input logic z, input int pcs, input int alu, input int cs, input int m2r,
                         input int jl, input int il, input int wc, input int lat, input int dc,
                         input int wm, input int mc);
        prog_t p;
        exp_t  e;
        p.instr = ins; p.iwait = iw; p.dwait = dw; p.zero = z;
        e.tag = tag; e.pcs = pcs; e.alu = alu; e.cs = cs; e.m2r = m2r; e.jl = jl; e.il = il;
        e.wc = wc; e.lat = lat; e.dc = dc; e.wm = wm; e.mc = mc;
        prog_q.push_back(p);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || prog_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", int'(exp_q.size() == 0 && prog_q.size() == 0), 1);
        run = 1'b0;
    endtask

    // Memory model: answers requests after the per-instruction wait counts.
    initial begin
        int  iw, dw, dw_init;
        bit  ibusy, dbusy;
        ack_i = 1'b0; ack_d = 1'b0; instr_v = 16'h0; zero_v = 1'b0;
        iw = 0; dw = 0; dw_init = 0; ibusy = 0; dbusy = 0;
        forever begin
            @(negedge clk);
            #2;
            ack_i = 1'b0;
            ack_d = 1'b0;
            if (!rst_n) begin
                ibusy = 0;
                dbusy = 0;
            end else begin
                if (m_imem_req && prog_q.size() > 0) begin
                    if (!ibusy) begin
                        ibusy = 1;
                        iw    = prog_q[0].iwait;
                    end
                    if (iw > 0) begin
                        iw--;
                    end else begin
                        ack_i   = 1'b1;
                        instr_v = prog_q[0].instr;
                        zero_v  = prog_q[0].zero;
                        dw_init = prog_q[0].dwait;
                        void'(prog_q.pop_front());
                        ibusy = 0;
                        dbusy = 0;
                    end
                end
                if (m_dmem_req) begin
                    if (!dbusy) begin
                        dbusy = 1;
                        dw    = dw_init;
                    end
                    if (dw > 0) begin
                        dw--;
                    end else begin
                        ack_d = 1'b1;
                        dbusy = 0;
                    end
                end
            end
        end
    end

    // Monitor: tracks each instruction from ir_we and scores it at pc_we.
    initial begin
        int   lat, dcyc, wcnt;
        bit   active, stable;
        logic wm, mc;
        exp_t e;
        lat = 0; dcyc = 0; wcnt = 0; active = 0; stable = 1; wm = 0; mc = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                active = 0;
            end else begin
                if (m_state == 3'd1) chk("decode_alu_zero", int'({m_ALUOp, m_alucsrc}), 0);
                if (m_ir_we) begin
                    active = 1; lat = 1; dcyc = 0; wcnt = 0; stable = 1;
                end else if (active) begin
                    lat++;
                end
                if (m_dmem_req) begin
                    if (dcyc == 0) begin
                        wm = m_wmem;
                        mc = m_memc;
                    end else if (m_wmem != wm || m_memc != mc) begin
                        stable = 0;
                    end
                    dcyc++;
                end
                if (m_wreg) wcnt++;
                if (m_pc_we) begin
                    chk("retire_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk({e.tag, ".PCsrc"},   int'(m_PCsrc),   e.pcs);
                        chk({e.tag, ".ALUOp"},   int'(m_ALUOp),   e.alu);
                        chk({e.tag, ".alucsrc"}, int'(m_alucsrc), e.cs);
                        chk({e.tag, ".m2reg"},   int'(m_m2reg),   e.m2r);
                        chk({e.tag, ".jal"},     int'(m_jal),     e.jl);
                        chk({e.tag, ".illegal"}, int'(m_illegal), e.il);
                        chk({e.tag, ".wreg_n"},  wcnt,            e.wc);
                        chk({e.tag, ".latency"}, lat,             e.lat);
                        chk({e.tag, ".mem_cyc"}, dcyc,            e.dc);
                        if (e.dc > 0) begin
                            chk({e.tag, ".wmem"},       int'(wm), e.wm);
                            chk({e.tag, ".memc"},       int'(mc), e.mc);
                            chk({e.tag, ".mem_stable"}, int'(stable), 1);
                        end
                    end
                    active = 0;
                end
            end
        end
    end

    // Stimulus: tag, instr, fetch wait, data wait, zero, then expected
    // PCsrc ALUOp alucsrc m2reg jal illegal wreg_count latency mem_cycles wmem memc.
    initial begin
        int n;
        rst_n = 1'b0; run = 1'b1; sel = 1'b0;
        step(); step();
        chk_zero("reset");
        rst_n = 1'b1;
        issue("add",    16'h8123, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        issue("beq_z0", 16'h2456, 0, 0, 1'b0, 1, 4, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        issue("beq_z1", 16'h2456, 0, 0, 1'b1, 0, 4, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        issue("ble_z0", 16'h3000, 0, 0, 1'b0, 1, 5, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        issue("ble_z1", 16'h3789, 0, 0, 1'b1, 0, 5, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        issue("lw_w3",  16'h5abc, 0, 3, 1'b0, 0, 0, 1, 1, 0, 0, 1, 8, 4, 0, 1);
        issue("sb",     16'h6001, 0, 0, 1'b0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 1, 0);
        issue("jalr",   16'h1000, 0, 0, 1'b0, 2, 0, 1, 0, 1, 0, 1, 4, 0, 0, 0);
        issue("jal",    16'h0000, 0, 0, 1'b0, 1, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0);
        issue("sub",    16'h9000, 0, 0, 1'b0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        issue("ori",    16'hF000, 2, 0, 1'b0, 0, 3, 1, 0, 0, 0, 1, 4, 0, 0, 0);
        issue("lb_w1",  16'h4000, 0, 1, 1'b0, 0, 0, 1, 1, 0, 0, 1, 6, 2, 0, 0);
        issue("sw_w2",  16'h7000, 0, 2, 1'b0, 0, 0, 1, 0, 0, 0, 0, 6, 3, 1, 1);
        issue("andi",   16'hE000, 0, 0, 1'b0, 0, 2, 1, 0, 0, 0, 1, 4, 0, 0, 0);
        wait_idle(400);

        // Asynchronous reset while in EXEC.
        run = 1'b1;
        issue("add_rst", 16'h8123, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        n = 0;
        while (m_state != 3'd2 && n < 20) begin
            step();
            n++;
        end
        chk("reach_exec", int'(m_state), 2);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_exec_reset");
        exp_q.delete();
        prog_q.delete();
        step();
        run = 1'b0;
        rst_n = 1'b1;

        // run=0 keeps FETCH idle even with an instruction waiting.
        issue("add_hold", 16'h8000, 3, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_no_req", int'(m_imem_req), 0);
        end

        // Drop run after the request rises: request holds until the late ack.
        run = 1'b1;
        #1;
        chk("req_rise", int'(m_imem_req), 1);
        step();
        run = 1'b0;
        #1;
        chk("req_held_1", int'(m_imem_req), 1);
        step();
        #1;
        chk("req_held_2", int'(m_imem_req), 1);
        wait_idle(100);

        // Wide-opcode instance: illegal opcode 0x13, then a legal add.
        sel = 1'b1;
        step();
        run = 1'b1;
        issue("illegal13", 16'h9800, 0, 0, 1'b0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
        issue("add_op5",   16'h4000, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        wait_idle(100);
        step();
        sel = 1'b0;

`ifdef MULTICYCLE_CTRL_PERF_EN
        // Three back-to-back adds: 3 retirements over 12 busy cycles.
        rst_n = 1'b0;
        step();
        chk("cyc_cnt_reset", int'(a_cyc), 0);
        chk("ret_cnt_reset", int'(a_ret), 0);
        for (int i = 0; i < 3; i++)
            issue("add_perf", 16'h8000, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        rst_n = 1'b1;
        run = 1'b1;
        wait_idle(100);
        step();
        chk("ret_cnt", int'(a_ret), 3);
        chk("cyc_cnt", int'(a_cyc), 12);
`endif

        step(); step();
        chk("leftover_expect", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the 16-bit CPU core. It replaces purely combinational opcode decode with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Latches the opcode from the fetched instruction and sequences the datapath strobes per state.
- Runs req/ack handshakes with instruction and data memory, so memories with variable wait states are supported.
- Sits between the instruction register/PC logic, ALU, register file and data memory.

Parameters:
- INSTR_W, 16: instruction width; opcode is instr[INSTR_W-1 -: OP_W].
- OP_W, 4: opcode width, >=4. Opcodes >=16 are illegal.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  1 = FETCH may start a new instruction.
- instr  in  INSTR_W  instruction word from instruction memory, valid with imem_ack.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; instr valid this cycle.
- zero  in  1  ALU flag; for beq/ble a value of 0 means the condition holds.
- dmem_req  out  1  data memory request.
- dmem_ack  in  1  data access complete.
- ir_we  out  1  instruction register load strobe.
- pc_we  out  1  PC update strobe, one cycle per retired instruction.
- PCsrc  out  2  0: PC+2, 1: PC+imm, 2: rs1+imm.
- ALUOp  out  3  0 add, 1 sub, 2 and, 3 or, 4 beq, 5 ble.
- alucsrc  out  1  0: register operand, 1: immediate.
- m2reg  out  1  1: writeback data comes from memory.
- wmem  out  1  1: write, 0: read; qualified by dmem_req.
- memc  out  1  0: byte, 1: 2-byte access.
- wreg  out  1  register file write strobe.
- jal  out  1  1: writeback data is the link address PC+2.
- illegal  out  1  one-cycle pulse on retiring an illegal opcode.
- state  out  3  current state, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH (0); op_q=0.
  - All outputs 0. Any outstanding request is abandoned with no retry.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH:
  - imem_req = run.
  - On imem_ack=1 while imem_req=1: ir_we=1, op_q <= opcode field, next state DECODE.
  - imem_req stays high until ack. Once raised, it is held even if run drops.
- DECODE: one cycle, no strobes. Next state EXEC.
- ALUOp and alucsrc are decoded from op_q and held stable in EXEC, MEM and WB. They are 0 in FETCH and DECODE.
- Opcode map (op: ALUOp/alucsrc):
  - jal 0: 0/0. jalr 1: 0/1. beq 2: 4/0. ble 3: 5/0.
  - lb 4, lw 5, sb 6, sw 7: 0/1.
  - add 8: 0/0. sub 9: 1/0. and 10: 2/0. or 11: 3/0.
  - addi 12: 0/1. subi 13: 1/1. andi 14: 2/1. ori 15: 3/1.
- EXEC transitions:
  - beq/ble: pc_we=1 and PCsrc = (zero==0) ? 1 : 0, both from zero sampled this cycle. Retire, next state FETCH.
  - lb/lw/sb/sw: next state MEM.
  - Illegal opcode: pc_we=1, PCsrc=0, illegal=1. Retire, next state FETCH.
  - All others: next state WB.
- MEM:
  - dmem_req=1, with wmem=(op is sb/sw) and memc=(op is lw/sw). wmem and memc are held stable until dmem_ack.
  - On dmem_ack, stores: pc_we=1, PCsrc=0, next state FETCH.
  - On dmem_ack, loads: next state WB.
- WB (exactly one cycle):
  - wreg=1 and pc_we=1.
  - m2reg=1 for lb/lw.
  - jal=1 for jal/jalr.
  - PCsrc: 1 for jal, 2 for jalr, 0 otherwise.
  - Next state FETCH.
- Minimum latency with zero-wait acks:
  - Branch: 3 cycles.
  - ALU op: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each extra wait cycle on either ack adds exactly one cycle.
- An ack arriving while its req=0 is ignored.
- pc_we, wreg, ir_we and illegal are never high for more than one cycle per instruction.
- wreg is never asserted for branches or stores.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_EN adds two outputs:
  - cyc_cnt [CNT_W]: increments every cycle while state!=FETCH or imem_req=1.
  - ret_cnt [CNT_W]: increments on every pc_we.
- Both counters are reset to 0 by rst_n and wrap modulo 2^CNT_W without saturation.
- Without the macro, neither port nor either counter exists and all other behaviour is identical.

Test Plan:
- Reset, then run=1, instr=0x8123 (add), immediate acks: ir_we at cycle 1, wreg and pc_we together at cycle 4 with PCsrc=0 and ALUOp=0. Assert rst_n low mid-EXEC: all outputs 0 and state=0 immediately.
- beq (0x2xxx) with zero=0 in EXEC: pc_we=1, PCsrc=1 in cycle 3 and wreg never asserted. Repeat with zero=1: PCsrc=0.
- lw (0x5xxx) with dmem_ack delayed 3 cycles: dmem_req, wmem=0 and memc=1 held for 4 cycles, then WB with m2reg=1, wreg=1; 8 cycles total.
- sb (0x6xxx), immediate ack: dmem_req=1, wmem=1, memc=0 for one cycle, pc_we in the same cycle, wreg stays 0.
- jalr (0x1xxx): WB with jal=1, wreg=1, PCsrc=2. With OP_W=5, opcode 0x13: illegal=1 and PCsrc=0 at EXEC, no wreg.
- run=0 in FETCH: imem_req stays 0 indefinitely. Drop run after imem_req rises: req holds until ack. With PERF_EN, 3 back-to-back adds give ret_cnt=3 and cyc_cnt=12.
